// File: rtl/uart_baud_gen.sv
// uart_baud_gen: fractional phase-accumulator UART timing generator producing
// oversample, mid-bit and bit-boundary ticks with runtime baud selection.
module uart_baud_gen #(
  parameter int              CLK_HZ     = 50_000_000,
  parameter int              OVERSAMPLE = 16,
  parameter int              ACC_W      = 28,
  parameter logic [8*24-1:0] BAUD_TABLE = {24'd921600, 24'd460800, 24'd230400, 24'd115200,
                                           24'd57600,  24'd38400,  24'd19200,  24'd9600}
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] baud_sel,
  input  logic       restart,
  output logic       os_tick,
  output logic       mid_tick,
  output logic       bit_tick,
  output logic       cfg_err
);
  localparam int              CW   = $clog2(OVERSAMPLE);
  localparam logic [ACC_W-1:0] LIM = ACC_W'(CLK_HZ);
  localparam logic [CW-1:0]   LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0]   HALF = CW'(OVERSAMPLE / 2 - 1);
  logic [ACC_W-1:0] acc_q, acc_d, inc, sum;
  logic [CW-1:0]    os_cnt_q, os_cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [23:0]      baud;
  logic             os_q, os_d, mid_q, mid_d, bit_q, bit_d, cfg_q;
  logic             bad, run, tick;
  assign baud = BAUD_TABLE[24*sel_q +: 24];
  assign inc  = ACC_W'(32'(baud) * 32'(OVERSAMPLE));
  assign bad  = inc >= LIM;
  assign sum  = acc_q + inc;
  // a baud change costs one dead cycle in which only sel_q moves
  assign run  = en & ~restart & (baud_sel == sel_q);
  assign tick = run & (bad | (sum >= LIM));
  always_comb begin
    sel_d    = (en & ~restart) ? baud_sel : sel_q;
    acc_d    = (!run || bad) ? '0 : (tick ? sum - LIM : sum);
    os_cnt_d = !run ? '0 : (!tick ? os_cnt_q : (os_cnt_q == LAST ? '0 : os_cnt_q + 1'b1));
    os_d     = tick;
    mid_d    = tick & (os_cnt_q == HALF);
    bit_d    = tick & (os_cnt_q == LAST);
  end
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      os_cnt_q <= '0;
      sel_q    <= '0;
      os_q     <= 1'b0;
      mid_q    <= 1'b0;
      bit_q    <= 1'b0;
      cfg_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      os_cnt_q <= os_cnt_d;
      sel_q    <= sel_d;
      os_q     <= os_d;
      mid_q    <= mid_d;
      bit_q    <= bit_d;
      cfg_q    <= bad;
    end
  end
  assign os_tick  = os_q;
  assign mid_tick = mid_q;
  assign bit_tick = bit_q;
  assign cfg_err  = cfg_q;
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: checks uart_baud_gen against an arithmetic tick-count model
// plus a second instance whose top table entry is an unattainable rate.
module tb_uart_baud_gen;
  localparam longint C = 50_000_000;
  logic       clk50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       restart = 1'b0;
  logic [2:0] baud_sel = 3'd0;
  logic       os1, mid1, bit1, cfg1;
  logic       os2, mid2, bit2, cfg2;
  int         vecs = 0;
  int         errs = 0;
  int         rates [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
  int         m_sel = 0;
  longint     m_n = 0;
  logic       e_os = 0, e_mid = 0, e_bit = 0, e_cfg = 0;

  always #5 clk50 = ~clk50;

  uart_baud_gen dut (.clk50(clk50), .rst_n(rst_n), .en(en), .baud_sel(baud_sel),
    .restart(restart), .os_tick(os1), .mid_tick(mid1), .bit_tick(bit1), .cfg_err(cfg1));

  uart_baud_gen #(.BAUD_TABLE({24'd4_000_000, 24'd460800, 24'd230400, 24'd115200,
                               24'd57600, 24'd38400, 24'd19200, 24'd9600}))
    dut2 (.clk50(clk50), .rst_n(rst_n), .en(en), .baud_sel(baud_sel),
    .restart(restart), .os_tick(os2), .mid_tick(mid2), .bit_tick(bit2), .cfg_err(cfg2));

  typedef struct { logic en, rs; logic [2:0] sel; logic os, mid, bt, cfg; } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ticks emitted after n accumulating edges since the last clear
  function automatic longint ticks(input longint n, input longint inc);
    return (inc >= C) ? n : (n * inc) / C;
  endfunction

  task automatic step();
    longint inc, k, kp;
    logic   cfg_pre;
    @(posedge clk50);
    inc     = longint'(rates[m_sel]) * 16;
    cfg_pre = inc >= C;
    {e_os, e_mid, e_bit} = 3'b000;
    if (!rst_n) begin
      m_sel = 0;
      m_n   = 0;
      cfg_pre = 1'b0;
    end else if (restart || !en) begin
      m_n = 0;
    end else if (int'(baud_sel) != m_sel) begin
      m_sel = int'(baud_sel);
      m_n   = 0;
    end else begin
      m_n++;
      k     = ticks(m_n, inc);
      kp    = ticks(m_n - 1, inc);
      e_os  = k != kp;
      e_mid = e_os && (k % 16 == 8);
      e_bit = e_os && (k % 16 == 0);
    end
    e_cfg = cfg_pre;
    #1;
    chk("os_tick", os1, e_os);
    chk("mid_tick", mid1, e_mid);
    chk("bit_tick", bit1, e_bit);
    chk("cfg_err", cfg1, e_cfg);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_os", os1, 0);
    chk("rst_mid", mid1, 0);
    chk("rst_bit", bit1, 0);
    chk("rst_cfg", cfg1, 0);
    chk("rst_os2", os2, 0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic first_tick(input string nm, input int exp);
    int lat = -1;
    for (int i = 1; i <= 2000; i++) begin
      step();
      if (os1) begin
        lat = i;
        break;
      end
    end
    chk(nm, lat, exp);
  endtask

  task automatic run_count(input int n, output int os_c, output int mid_c, output int bit_c);
    os_c = 0; mid_c = 0; bit_c = 0;
    for (int i = 0; i < n; i++) begin
      step();
      os_c += int'(os1);
      mid_c += int'(mid1);
      bit_c += int'(bit1);
    end
  endtask

  initial begin
    int oc, mc, bc, last_b, gap, got;
    // unattainable-rate table run on dut2
    tbl[0]  = '{1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 3; i <= 10; i++) tbl[i] = '{1'b1, 1'b0, 3'd7, 1'b1, i == 10, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1};
    step();
    step();
    chk("reset_os", os1, 0);
    chk("reset_cfg", cfg1, 0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en;
      restart = tbl[i].rs;
      baud_sel = tbl[i].sel;
      step();
      chk($sformatf("tbl%0d_os", i), os2, tbl[i].os);
      chk($sformatf("tbl%0d_mid", i), mid2, tbl[i].mid);
      chk($sformatf("tbl%0d_bit", i), bit2, tbl[i].bt);
      chk($sformatf("tbl%0d_cfg", i), cfg2, tbl[i].cfg);
    end
    // cfg_err: tick every cycle, bit every 16
    en = 1'b1; restart = 1'b0;
    oc = 0; bc = 0; last_b = 0; gap = 0;
    for (int i = 1; i <= 48; i++) begin
      step();
      oc += int'(os2);
      if (bit2) begin
        gap = i - last_b;
        last_b = i;
        bc++;
      end
    end
    chk("cfg_os_count", oc, 48);
    chk("cfg_bit_count", bc, 3);
    chk("cfg_bit_gap", gap, 16);
    // 9600 from reset
    en = 1'b0; baud_sel = 3'd0;
    do_reset();
    en = 1'b1;
    first_tick("first_9600", 326);
    for (int g = 0; g < 6; g++) begin
      got = 0;
      for (int i = 1; i <= 400; i++) begin
        step();
        if (os1) begin
          got = i;
          break;
        end
      end
      chk("gap_9600_ok", (got == 325 || got == 326), 1);
    end
    // 921600 long-run exactness
    baud_sel = 3'd7;
    step();
    run_count(15625, oc, mc, bc);
    chk("os_4608", oc, 4608);
    chk("mid_288", mc, 288);
    chk("bit_288", bc, 288);
    chk("acc_zero", dut.acc_q, 0);
    // restart realignment at 57600
    baud_sel = 3'd3;
    step();
    oc = 0;
    for (int i = 0; i < 3000 && oc < 20; i++) begin
      step();
      oc += int'(os1);
    end
    chk("twenty_ticks", oc, 20);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_cnt", dut.os_cnt_q, 0);
    oc = 0; got = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      oc += int'(os1);
      if (mid1) begin
        got = oc;
        break;
      end
    end
    chk("mid_after_restart", got, 8);
    // baud change mid-bit
    baud_sel = 3'd0;
    step();
    for (int i = 0; i < 500; i++) step();
    baud_sel = 3'd4;
    step();
    chk("chg_dead_os", os1, 0);
    chk("chg_cnt", dut.os_cnt_q, 0);
    first_tick("first_115200", 28);
    run_count(15625, oc, mc, bc);
    chk("os_576", oc, 576);
    // en low mid-bit
    for (int i = 0; i < 100; i++) step();
    en = 1'b0;
    step();
    chk("en_low_cnt", dut.os_cnt_q, 0);
    en = 1'b1;
    first_tick("first_after_en", 28);
    // async reset mid-bit, then dead cycle from sel 0 -> 4
    for (int i = 0; i < 77; i++) step();
    do_reset();
    first_tick("first_after_rst", 29);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en = $urandom_range(0, 31) != 0;
      restart = $urandom_range(0, 63) == 0;
      if ($urandom_range(0, 199) == 0) baud_sel = 3'($urandom_range(0, 7));
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
